core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Top-level execution controller for the 8-bit single-issue core.
- Launches a program and drives the PC's freeze, reset and advance controls.
- Stretches multi-cycle and memory instructions; gates register-file commit.
- Reports completion and performance counts to the testbench/host.
- Sits between the host handshake, the instruction decoder, the data-memory port and the program counter.

Parameters:
- STALL_CYC, 4, total cycles spent by a multi-cycle instruction (range 2..15).
- CNT_W, 16, width of the cycle and retired-instruction counters.
- WD_LIMIT, 32, maximum MemAck wait cycles (used only with the watchdog).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Req  in  1  host run request, level-sensitive
- HaltOp  in  1  decoded instruction at current PC is halt
- MemOp  in  1  decoded instruction accesses data memory
- MultiCyc  in  1  decoded instruction needs STALL_CYC cycles
- MemAck  in  1  data memory completion, one-cycle pulse
- Start  out  1  high = PC frozen (core idle)
- PcReset  out  1  forces PC to 0 next edge
- PcEn  out  1  PC advances (PC+1 or branch) next edge
- Commit  out  1  register/flag writeback enable
- MemStrobe  out  1  one-cycle memory request pulse
- Done  out  1  program halted
- Err  out  1  watchdog fault (tied 0 without the feature)
- CycleCnt  out  CNT_W  cycles since launch, saturating
- InstrCnt  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset, from any state: state=IDLE; Start=1; all other outputs 0; counters 0; stall counter 0. A mid-program reset aborts with no Commit.
- All outputs are registered-state Moore decodes except PcEn, Commit and MemStrobe. These three are combinational from state plus the decoder inputs in the same cycle.
- IDLE: Start=1. Req=1 -> LAUNCH.
- LAUNCH: one cycle. Start=0, PcReset=1, counters cleared to 0. Next state is RUN.
- RUN: one instruction is decoded per cycle. Decode priority is HaltOp > MemOp > MultiCyc > plain.
  - HaltOp: PcEn=0, Commit=0, InstrCnt+1, next state DONE.
  - MemOp: MemStrobe=1, PcEn=0, next state MEM_WAIT.
  - MultiCyc: PcEn=0, stall counter loaded with STALL_CYC-2, next state STALL.
  - plain: PcEn=1, Commit=1, InstrCnt+1, stay in RUN.
- STALL: PcEn=0 while the stall counter is nonzero; the counter decrements each cycle.
  - When the counter is 0: PcEn=1, Commit=1, InstrCnt+1, next state RUN.
  - Total instruction length is exactly STALL_CYC cycles.
- MEM_WAIT: PcEn=0, MemStrobe=0.
  - MemAck is sampled only in MEM_WAIT; a MemAck coincident with MemStrobe is ignored.
  - MemAck=1: PcEn=1, Commit=1, InstrCnt+1, next state RUN.
- DONE: Start=1, Done=1; held while Req=1.
  - Req=0 -> IDLE, with Done cleared the next cycle.
  - A fresh Req in IDLE relaunches.
- CycleCnt increments in RUN, STALL and MEM_WAIT only. Both counters saturate at all-ones with no wrap.
- Req deasserted mid-program is ignored; the program runs to halt.
- Decoder inputs are ignored outside RUN.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro: a wait counter runs in MEM_WAIT. If WD_LIMIT cycles elapse without MemAck, the block goes to DONE with Err=1 and no Commit.
  - Err stays high until the next LAUNCH or Reset.
  - MemAck on the limit cycle wins: it is treated as a normal completion.
- Without the macro: MEM_WAIT waits indefinitely and Err is constant 0.

Decomposition:
- seq_pkg holds:
  - state enum seq_state_t (IDLE, LAUNCH, RUN, STALL, MEM_WAIT, DONE);
  - default constants for STALL_CYC, CNT_W and WD_LIMIT.
- Sub-module sat_counter (parameterised width, clear and enable inputs), instantiated for CycleCnt and InstrCnt.

Test Plan:
- Reset, then Req=1 with a 3-plain-instruction program followed by halt:
  - PcReset pulses in LAUNCH;
  - Commit is high 3 cycles;
  - Done=1 with InstrCnt=4 and CycleCnt=4;
  - Start=1 after the halt.
- MultiCyc instruction with STALL_CYC=4: PcEn is low 3 cycles and high on the 4th; Commit is high once; CycleCnt increases by 4.
- MemOp with MemAck 5 cycles after MemStrobe: one MemStrobe pulse; PcEn and Commit fire in the MemAck cycle; no double commit.
- HaltOp and MemOp asserted together: no MemStrobe; next state DONE.
- Reset asserted in STALL: Start=1, counters 0, no Commit. A later Req relaunches cleanly from PC 0.
- With SEQ_WATCHDOG_EN and WD_LIMIT=32, MemOp with MemAck never asserted: Done=1 and Err=1 after 32 wait cycles; InstrCnt unchanged. Relaunch clears Err.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default parameters for the core execution sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        STALL,
        MEM_WAIT,
        DONE
    } seq_state_t;

    localparam int unsigned STALL_CYC_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned WD_LIMIT_DEF  = 32;

endpackage

// File: rtl/core_sequencer_if.sv
// Host, decoder and data-memory signals seen by the sequencer, bundled with modports.
interface core_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             Req;
    logic             HaltOp;
    logic             MemOp;
    logic             MultiCyc;
    logic             MemAck;
    logic             Start;
    logic             PcReset;
    logic             PcEn;
    logic             Commit;
    logic             MemStrobe;
    logic             Done;
    logic             Err;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstrCnt;

    modport master (
        output Req, HaltOp, MemOp, MultiCyc, MemAck,
        input  Start, PcReset, PcEn, Commit, MemStrobe, Done, Err, CycleCnt, InstrCnt
    );

    modport slave (
        input  Req, HaltOp, MemOp, MultiCyc, MemAck,
        output Start, PcReset, PcEn, Commit, MemStrobe, Done, Err, CycleCnt, InstrCnt
    );

endinterface

// File: rtl/core_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_sequencer.sv
// Execution controller for the 8-bit core: launch, stall/memory stretching, commit gating, counters.
// Define SEQ_WATCHDOG_EN to add the MemAck wait watchdog that raises Err.
//
// state    | meaning
// IDLE     | PC frozen, waiting for Req
// LAUNCH   | one cycle: PC forced to 0, counters cleared
// RUN      | one instruction decoded per cycle
// STALL    | multi-cycle instruction in progress
// MEM_WAIT | memory request issued, waiting for MemAck
// DONE     | halted; held while Req stays high
module core_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned STALL_CYC = STALL_CYC_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned WD_LIMIT  = WD_LIMIT_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    core_sequencer_if.slave  bus
);

    localparam int unsigned STL_W = 4;

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [STL_W-1:0]   r_stall_cnt;
    logic               w_pc_en;
    logic               w_commit;
    logic               w_mem_strobe;
    logic               w_retire;
    logic               w_stall_load;
    logic               w_cyc_en;
    logic               w_cnt_clr;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_err;
    logic               w_wd_trip;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_stall_load) begin
                r_stall_cnt <= STL_W'(STALL_CYC - 2);
            end else if ((r_state == STALL) && (r_stall_cnt != '0)) begin
                r_stall_cnt <= r_stall_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pc_en      = 1'b0;
        w_commit     = 1'b0;
        w_mem_strobe = 1'b0;
        w_retire     = 1'b0;
        w_stall_load = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        w_wd_trip    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.Req) w_next = LAUNCH;
            end
            LAUNCH: begin
                w_next = RUN;
            end
            RUN: begin
                // Halt retires but never writes back.
                if (bus.HaltOp) begin
                    w_retire = 1'b1;
                    w_next   = DONE;
                end else if (bus.MemOp) begin
                    w_mem_strobe = 1'b1;
                    w_next       = MEM_WAIT;
                end else if (bus.MultiCyc) begin
                    w_stall_load = 1'b1;
                    w_next       = STALL;
                end else begin
                    w_pc_en  = 1'b1;
                    w_commit = 1'b1;
                    w_retire = 1'b1;
                end
            end
            STALL: begin
                if (r_stall_cnt == '0) begin
                    w_pc_en  = 1'b1;
                    w_commit = 1'b1;
                    w_retire = 1'b1;
                    w_next   = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.MemAck) begin
                    w_pc_en  = 1'b1;
                    w_commit = 1'b1;
                    w_retire = 1'b1;
                    w_next   = RUN;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (r_wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                    w_wd_trip = 1'b1;
                    w_next    = DONE;
                end
`endif
            end
            DONE: begin
                if (!bus.Req) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    // Wait count restarts on every MEM_WAIT entry; Err clears as the next launch begins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == MEM_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_next == LAUNCH) begin
                r_err <= 1'b0;
            end else if (w_wd_trip) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.Err = r_err;
`else
    assign bus.Err = 1'b0;
`endif

    assign w_cyc_en  = (r_state == RUN) || (r_state == STALL) || (r_state == MEM_WAIT);
    assign w_cnt_clr = (r_state == LAUNCH);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cyc_en),
        .o_cnt (bus.CycleCnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_retire),
        .o_cnt (bus.InstrCnt)
    );

    assign bus.Start     = (r_state == IDLE) || (r_state == DONE);
    assign bus.PcReset   = (r_state == LAUNCH);
    assign bus.Done      = (r_state == DONE);
    assign bus.PcEn      = w_pc_en;
    assign bus.Commit    = w_commit;
    assign bus.MemStrobe = w_mem_strobe;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed per-cycle vector table plus hand sequences for watchdog/long-wait and counter saturation.
module tb_core_sequencer;
    import seq_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    core_sequencer_if #(.CNT_W(16)) bus ();
    core_sequencer_if #(.CNT_W(3))  sbus ();

    core_sequencer #(.STALL_CYC(4), .CNT_W(16), .WD_LIMIT(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    core_sequencer #(.STALL_CYC(4), .CNT_W(3), .WD_LIMIT(32)) dut_sat (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (sbus)
    );

    // flags order: {Start, PcReset, PcEn, Commit, MemStrobe, Done, Err}
    typedef struct {
        logic        rst;
        logic        req;
        logic        halt;
        logic        mem;
        logic        mc;
        logic        ack;
        logic [6:0]  flags;
        logic [15:0] cyc;
        logic [15:0] ins;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t v(input logic rst, input logic req, input logic halt,
                               input logic mem, input logic mc, input logic ack,
                               input logic [6:0] flags, input int cyc, input int ins);
        vec_t r;
        r.rst = rst; r.req = req; r.halt = halt; r.mem = mem; r.mc = mc; r.ack = ack;
        r.flags = flags; r.cyc = 16'(cyc); r.ins = 16'(ins);
        return r;
    endfunction

    function automatic logic [6:0] flags_of_main();
        return {bus.Start, bus.PcReset, bus.PcEn, bus.Commit, bus.MemStrobe, bus.Done, bus.Err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic halt, input logic mem,
                         input logic mc, input logic ack);
        @(negedge Clk);
        bus.Req = req; bus.HaltOp = halt; bus.MemOp = mem; bus.MultiCyc = mc; bus.MemAck = ack;
        #1;
    endtask

    task automatic drive_s(input logic req, input logic halt);
        @(negedge Clk);
        sbus.Req = req; sbus.HaltOp = halt; sbus.MemOp = 1'b0; sbus.MultiCyc = 1'b0; sbus.MemAck = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        bus.Req = 0; bus.HaltOp = 0; bus.MemOp = 0; bus.MultiCyc = 0; bus.MemAck = 0;
        sbus.Req = 0; sbus.HaltOp = 0; sbus.MemOp = 0; sbus.MultiCyc = 0; sbus.MemAck = 0;

        //             rst req hlt mem mc ack  flags         cyc ins
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000000, 0, 0));  // IDLE, launch requested
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0100000, 0, 0));  // LAUNCH
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0011000, 0, 0));  // plain 1
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0011000, 1, 1));  // plain 2
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0011000, 2, 2));  // plain 3
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 7'b0000000, 3, 3));  // halt
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000010, 4, 4));  // DONE held
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000010, 4, 4));  // Req drop
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000000, 4, 4));  // IDLE, Done cleared
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000000, 4, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b0100000, 4, 4));  // LAUNCH, Req low ignored
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 7'b0000000, 0, 0));  // multicycle starts
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 7'b0000000, 1, 0));  // STALL, decoder ignored
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b0000000, 2, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b0011000, 3, 0));  // 4th cycle retires
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 7'b0000000, 4, 1));  // halt beats mem
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000010, 5, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000000, 5, 2));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0100000, 5, 2));
        vecs.push_back(v(0, 1, 0, 1, 0, 1, 7'b0000100, 0, 0));  // MemStrobe, coincident ack ignored
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 7'b0000000, 1, 0));  // MEM_WAIT, no re-strobe
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0000000, 2, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0000000, 3, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0000000, 4, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 7'b0011000, 5, 0));  // MemAck 5 cycles after strobe
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 7'b0011000, 6, 1));  // plain, stray ack ignored
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 7'b0000000, 7, 2));  // multicycle
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0000000, 8, 2));  // STALL
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 7'b0000000, 9, 2));  // reset in STALL
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000000, 0, 0));  // aborted, counters cleared
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000000, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b0100000, 0, 0));  // relaunch from PC 0
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 7'b0000000, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000010, 1, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 7'b1000010, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000010, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 7'b1000000, 1, 1));

        repeat (2) @(posedge Clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            Reset = vecs[i].rst;
            bus.Req = vecs[i].req; bus.HaltOp = vecs[i].halt; bus.MemOp = vecs[i].mem;
            bus.MultiCyc = vecs[i].mc; bus.MemAck = vecs[i].ack;
            #1;
            chk($sformatf("row%0d flags", i), 32'(flags_of_main()), 32'(vecs[i].flags));
            chk($sformatf("row%0d cyc", i), 32'(bus.CycleCnt), 32'(vecs[i].cyc));
            chk($sformatf("row%0d ins", i), 32'(bus.InstrCnt), 32'(vecs[i].ins));
        end
        Reset = 1'b0;

        // Long memory wait: watchdog trip or indefinite wait, then a clean completion.
        drive(1, 0, 0, 0, 0);                      // IDLE
        drive(1, 0, 0, 0, 0);                      // LAUNCH
        drive(1, 0, 0, 0, 0);                      // plain
        drive(1, 0, 1, 0, 0);                      // mem request
        chk("wd strobe", 32'(bus.MemStrobe), 32'd1);
`ifdef SEQ_WATCHDOG_EN
        for (int k = 1; k <= 32; k++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("wd wait%0d done/err", k), 32'({bus.Done, bus.Err, bus.Commit}), 32'd0);
        end
        drive(1, 0, 0, 0, 0);                      // DONE via timeout
        chk("wd trip done/err", 32'({bus.Done, bus.Err}), 32'b11);
        chk("wd trip ins", 32'(bus.InstrCnt), 32'd1);
        chk("wd trip cyc", 32'(bus.CycleCnt), 32'd34);
        drive(0, 0, 0, 0, 0);                      // leave DONE
        drive(0, 0, 0, 0, 0);                      // IDLE
        chk("wd idle err held", 32'({bus.Done, bus.Err}), 32'b01);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);                      // LAUNCH
        drive(1, 0, 1, 0, 0);                      // RUN, mem
        chk("wd relaunch err", 32'(bus.Err), 32'd0);
        for (int k = 1; k < 32; k++) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);                      // ack on the limit cycle
        chk("wd limit ack", 32'({bus.PcEn, bus.Commit, bus.Err}), 32'b110);
        drive(1, 0, 0, 0, 0);
        chk("wd limit run", 32'({bus.Done, bus.Err}), 32'b00);
        chk("wd limit ins", 32'(bus.InstrCnt), 32'd1);
        drive(1, 1, 0, 0, 0);
`else
        for (int k = 1; k <= 40; k++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("nowd wait%0d", k), 32'({bus.Done, bus.Err, bus.Commit, bus.PcEn}), 32'd0);
        end
        drive(1, 0, 0, 0, 1);
        chk("nowd late ack", 32'({bus.PcEn, bus.Commit}), 32'b11);
        drive(1, 1, 0, 0, 0);                      // halt
        chk("nowd ins", 32'(bus.InstrCnt), 32'd2);
        chk("nowd cyc", 32'(bus.CycleCnt), 32'd43);
`endif
        drive(0, 0, 0, 0, 0);
        chk("seq end done", 32'({bus.Done, bus.Err}), 32'b10);
        drive(0, 0, 0, 0, 0);

        // Saturation on the 3-bit instance.
        drive_s(1, 0);                             // IDLE
        drive_s(1, 0);                             // LAUNCH
        for (int k = 0; k < 10; k++) begin
            drive_s(1, 0);
            chk($sformatf("sat cyc k%0d", k), 32'(sbus.CycleCnt), (k < 7) ? k : 7);
            chk($sformatf("sat ins k%0d", k), 32'(sbus.InstrCnt), (k < 7) ? k : 7);
        end
        drive_s(1, 1);                             // halt at saturation
        drive_s(0, 0);
        chk("sat done", 32'(sbus.Done), 32'd1);
        chk("sat final cyc", 32'(sbus.CycleCnt), 32'd7);
        chk("sat final ins", 32'(sbus.InstrCnt), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
